// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CONTROL /
// STATUS bit positions, FSM state encoding and a STATUS packing helper.
package led_seq_pkg;

  localparam int DATA_W = 32;
  // Index, LENGTH and TBL_PTR fields are all 3 bits wide.
  localparam int IDX_W  = 3;

  typedef enum logic [2:0] {
    REG_CONTROL  = 3'd0,
    REG_STATUS   = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_LENGTH   = 3'd3,
    REG_TBL_PTR  = 3'd4,
    REG_TBL_DATA = 3'd5
  } reg_addr_e;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_ONE_SHOT_BIT = 1;

  localparam int STAT_RUNNING_BIT  = 0;
  localparam int STAT_DONE_BIT     = 1;
  localparam int STAT_IDX_LSB      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_e;

  // Assemble the STATUS word from its fields; unused bits read as zero.
  function automatic logic [DATA_W-1:0] pack_status(input logic             running,
                                                    input logic             done,
                                                    input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w                            = '0;
    w[STAT_RUNNING_BIT]          = running;
    w[STAT_DONE_BIT]             = done;
    w[STAT_IDX_LSB +: IDX_W]     = idx;
    return w;
  endfunction

endpackage

// File: rtl/led_seq_timer.sv
// Dwell down-counter: load a step length, count down while ticking, flag the
// final cycle of the dwell so the sequencer can act on it.
module led_seq_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over tick; the counter parks at zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The cycle holding count 1 is the last dwell cycle of the step.
  assign expire_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a small register file on slave s1 holds a pattern
// table and timing; an FSM replays the table to an LED PIO over master m1,
// one write per step with a programmable dwell between writes.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int TABLE_DEPTH = 8,
  parameter int PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                reset,
  // slave s1
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  // master m1 to the LED PIO
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic                  enable_q, enable_d;
  logic                  one_shot_q, one_shot_d;
  logic                  done_q, done_d;
  logic [PERIOD_W-1:0]   period_q;
  logic [IDX_W-1:0]      length_q;
  logic [IDX_W-1:0]      tbl_ptr_q;
  logic [7:0]            table_q [TABLE_DEPTH];

  // Pattern byte frozen at WRITE entry so the bus stays stable while stalled
  // even if software rewrites the table entry mid-transfer.
  logic [7:0]            wdata_q, wdata_d;

  // ---------------------------------------------------------------------------
  // Slave write decode (zero wait states)
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic wr_control, wr_status, wr_period, wr_length, wr_tbl_ptr, wr_tbl_data;

  assign wr_en       = chipselect && !write_n;
  assign wr_control  = wr_en && (address == REG_CONTROL);
  assign wr_status   = wr_en && (address == REG_STATUS);
  assign wr_period   = wr_en && (address == REG_PERIOD);
  assign wr_length   = wr_en && (address == REG_LENGTH);
  assign wr_tbl_ptr  = wr_en && (address == REG_TBL_PTR);
  assign wr_tbl_data = wr_en && (address == REG_TBL_DATA);

  // Only the low bits of writedata land in registers; the rest are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // ---------------------------------------------------------------------------
  // Dwell timer
  // ---------------------------------------------------------------------------
  logic                timer_load;
  logic                timer_tick;
  logic                timer_expire;
  logic [PERIOD_W-1:0] dwell_len;

  // A PERIOD of zero still dwells for one cycle.
  assign dwell_len  = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign timer_tick = (state_q == ST_DWELL);

  led_seq_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (dwell_len),
    .tick_i     (timer_tick),
    .expire_o   (timer_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic seq_start;   // IDLE -> WRITE launch of a new sequence
  logic seq_finish;  // one-shot sequence completed its last step
  logic running;

  assign running = (state_q != ST_IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and step sequencing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seq_start  = 1'b0;
    seq_finish = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d   = ST_WRITE;
          idx_d     = '0;
          seq_start = 1'b1;
        end
      end
      ST_WRITE: begin
        // A transfer is never abandoned; disable is honoured once it lands.
        if (!m_waitrequest) begin
          timer_load = 1'b1;
          state_d    = enable_q ? ST_DWELL : ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (timer_expire) begin
          // idx >= LENGTH also covers LENGTH shrunk below the running index.
          if (idx_q < length_q) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_WRITE;
          end else if (!one_shot_q) begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end else begin
            // Park the index at 0 so a finished run reads back as plain done.
            idx_d      = '0;
            state_d    = ST_IDLE;
            seq_finish = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: master bus driven only while in WRITE.
  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 2'd0;
    m_writedata  = '0;
    if (state_q == ST_WRITE) begin
      m_chipselect = 1'b1;
      m_write_n    = 1'b0;
      m_writedata  = {24'd0, wdata_q};
    end
  end

  // Capture the pattern byte for the step that is about to be written.
  always_comb begin
    wdata_d = wdata_q;
    if ((state_d == ST_WRITE) && (state_q != ST_WRITE)) begin
      wdata_d = table_q[idx_d];
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status next values
  // ---------------------------------------------------------------------------
  // Software writes first, then hardware events override them.
  always_comb begin
    enable_d   = enable_q;
    one_shot_d = one_shot_q;
    done_d     = done_q;
    if (wr_control) begin
      enable_d   = writedata[CTRL_ENABLE_BIT];
      one_shot_d = writedata[CTRL_ONE_SHOT_BIT];
    end
    if (seq_finish) begin
      enable_d = 1'b0;
    end
    // Hardware set of done beats a coincident write-1-to-clear.
    if (seq_finish) begin
      done_d = 1'b1;
    end else if (seq_start) begin
      done_d = 1'b0;
    end else if (wr_status && writedata[STAT_DONE_BIT]) begin
      done_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control, timing and sequencing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= 1'b0;
      one_shot_q <= 1'b0;
      done_q     <= 1'b0;
      period_q   <= '0;
      length_q   <= '0;
      tbl_ptr_q  <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      enable_q   <= enable_d;
      one_shot_q <= one_shot_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      if (wr_period) begin
        period_q <= writedata[PERIOD_W-1:0];
      end
      if (wr_length) begin
        length_q <= writedata[IDX_W-1:0];
      end
      if (wr_tbl_data) begin
        tbl_ptr_q <= tbl_ptr_q + IDX_W'(1);
      end else if (wr_tbl_ptr) begin
        tbl_ptr_q <= writedata[IDX_W-1:0];
      end
    end
  end

  // Pattern table storage, written through TBL_DATA at the current pointer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the table is deliberately reset so a fresh sequence never emits
    // stale patterns; this keeps it in flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (wr_tbl_data) begin
      table_q[tbl_ptr_q] <= writedata[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Slave read mux (combinational, zero-extended)
  // ---------------------------------------------------------------------------
  // Read data selected directly by address.
  always_comb begin
    readdata = '0;
    case (address)
      REG_CONTROL: begin
        readdata[CTRL_ENABLE_BIT]   = enable_q;
        readdata[CTRL_ONE_SHOT_BIT] = one_shot_q;
      end
      REG_STATUS:   readdata = pack_status(running, done_q, idx_q);
      REG_PERIOD:   readdata = DATA_W'(period_q);
      REG_LENGTH:   readdata = DATA_W'(length_q);
      REG_TBL_PTR:  readdata = DATA_W'(tbl_ptr_q);
      REG_TBL_DATA: readdata = DATA_W'(table_q[tbl_ptr_q]);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus
// randomized one-shot runs, with a scoreboard of expected master writes.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  localparam int PW = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .TABLE_DEPTH (8),
    .PERIOD_W    (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Shadow of software-visible configuration and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    int         gap;   // cycles since previous accepted write, 0 = unchecked
  } xfer_t;

  xfer_t      exp_q[$];
  logic [7:0] sh_tbl [8];
  int         sh_ptr, sh_period, sh_length;
  bit         stall_rand = 1'b0;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: a run writes entries 0..LENGTH in order (wrapping when
  // continuous), each accepted write max(PERIOD,1)+1 cycles after the last.
  task automatic expect_steps(input int n, input bit chk_gap);
    int    idx;
    int    dwell;
    xfer_t e;
    idx   = 0;
    dwell = (sh_period == 0) ? 1 : sh_period;
    for (int k = 0; k < n; k++) begin
      e.data = sh_tbl[idx];
      e.gap  = (k == 0 || !chk_gap) ? 0 : dwell + 1;
      exp_q.push_back(e);
      idx = (idx >= sh_length) ? 0 : idx + 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: samples 1 time unit after the falling edge, i.e. the values the
  // next rising edge will see.
  // ---------------------------------------------------------------------------
  int          n_accepted = 0;
  int          last_run   = 0;
  int          run_len    = 0;
  int          last_acc   = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  xfer_t       got;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      run_len    = 0;
      prev_stall = 1'b0;
    end else if (!m_chipselect) begin
      run_len    = 0;
      prev_stall = 1'b0;
      check("idle_ctrl", {29'd0, m_write_n, m_address}, 32'h4);
      check("idle_wdata", m_writedata, 32'h0);
    end else begin
      run_len++;
      if (prev_stall) begin
        check("stall_wdata", m_writedata, prev_data);
        check("stall_ctrl", {29'd0, m_write_n, m_address}, 32'h0);
      end
      prev_stall = m_waitrequest;
      prev_data  = m_writedata;
      if (!m_waitrequest) begin
        n_accepted++;
        last_run   = run_len;
        run_len    = 0;
        prev_stall = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got data 0x%08h, expected no transfer", m_writedata);
        end else begin
          got = exp_q.pop_front();
          check("xfer_data", m_writedata, {24'd0, got.data});
          if (got.gap > 0) check("xfer_gap", cycle - last_acc, got.gap);
        end
        last_acc = cycle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    case (a)
      3'd2: sh_period = int'(d[PW-1:0]);
      3'd3: sh_length = int'(d[2:0]);
      3'd4: sh_ptr    = int'(d[2:0]);
      3'd5: begin
        sh_tbl[sh_ptr] = d[7:0];
        sh_ptr         = (sh_ptr + 1) % 8;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    address    = 3'd0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      if (stall_rand) m_waitrequest = ($urandom_range(0, 2) == 0);
      k++;
    end
    m_waitrequest = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] s;
    int          k;
    k = 0;
    do begin
      bus_read(REG_STATUS, s);
      k++;
    end while (s[0] && k < budget);
    if (s[0]) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: running=1, expected 0");
    end
  endtask

  task automatic wait_cs(input int budget);
    int k;
    k = 0;
    while (!m_chipselect && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!m_chipselect) begin
      n_checks++;
      n_fail++;
      $display("FAIL cs_timeout: m_chipselect=0, expected 1");
    end
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 8; i++) sh_tbl[i] = 8'h00;
    sh_ptr    = 0;
    sh_period = 0;
    sh_length = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_cs"}, {31'd0, m_chipselect}, 32'd0);
    check({tag, "_m_wn"}, {31'd0, m_write_n}, 32'd1);
    check({tag, "_m_wdata"}, m_writedata, 32'd0);
    check({tag, "_m_addr"}, {30'd0, m_address}, 32'd0);
  endtask

  // Global watchdog.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          acc0;
    logic [31:0] d;
    int          pick;

    reset         = 1'b1;
    address       = 3'd0;
    chipselect    = 1'b0;
    write_n       = 1'b1;
    writedata     = 32'd0;
    m_waitrequest = 1'b0;
    clear_shadow();

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    read_check("rst_control", REG_CONTROL, 32'h0);
    read_check("rst_status", REG_STATUS, 32'h0);
    read_check("rst_period", REG_PERIOD, 32'h0);
    read_check("rst_tbl_ptr", REG_TBL_PTR, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Continuous 3-step pattern, PERIOD=3: 01,02,04,01,... 4 cycles apart.
    bus_write(REG_TBL_PTR, 0);
    bus_write(REG_TBL_DATA, 32'h01);
    bus_write(REG_TBL_DATA, 32'h02);
    bus_write(REG_TBL_DATA, 32'h04);
    bus_write(REG_LENGTH, 2);
    bus_write(REG_PERIOD, 3);
    read_check("period_rb", REG_PERIOD, 32'd3);
    read_check("length_rb", REG_LENGTH, 32'd2);
    expect_steps(7, 1'b1);
    bus_write(REG_CONTROL, 32'h1);
    wait_drain(200);
    bus_write(REG_CONTROL, 32'h0);
    wait_idle(20);
    read_check("cont_stopped_status", REG_STATUS, 32'h0);

    // Unmapped addresses read zero and ignore writes.
    bus_write(3'd6, 32'hFFFF_FFFF);
    read_check("addr6_read", 3'd6, 32'h0);
    read_check("addr7_read", 3'd7, 32'h0);
    read_check("ctrl_after_addr6", REG_CONTROL, 32'h0);

    // One-shot, LENGTH=1, PERIOD=2: exactly 01,02 then done.
    bus_write(REG_LENGTH, 1);
    bus_write(REG_PERIOD, 2);
    expect_steps(2, 1'b1);
    bus_write(REG_CONTROL, 32'h3);
    wait_drain(100);
    wait_idle(20);
    repeat (10) @(negedge clk);
    read_check("oneshot_status", REG_STATUS, 32'h2);
    read_check("oneshot_control", REG_CONTROL, 32'h2);
    bus_write(REG_STATUS, 32'h2);
    read_check("done_w1c", REG_STATUS, 32'h0);

    // Waitrequest held 5 cycles: bus stable 6 cycles, single transfer.
    acc0          = n_accepted;
    m_waitrequest = 1'b1;
    bus_write(REG_LENGTH, 0);
    expect_steps(1, 1'b0);
    bus_write(REG_CONTROL, 32'h3);
    wait_cs(20);
    repeat (5) @(negedge clk);
    m_waitrequest = 1'b0;
    wait_drain(20);
    check("stall_cycles", last_run, 6);
    wait_idle(20);
    check("stall_single_xfer", n_accepted - acc0, 1);
    read_check("stall_status", REG_STATUS, 32'h2);

    // Disable during a stalled WRITE: transfer completes, then stop.
    acc0          = n_accepted;
    m_waitrequest = 1'b1;
    bus_write(REG_LENGTH, 2);
    expect_steps(1, 1'b0);
    bus_write(REG_CONTROL, 32'h1);
    wait_cs(20);
    bus_write(REG_CONTROL, 32'h0);
    repeat (2) @(negedge clk);
    m_waitrequest = 1'b0;
    wait_drain(20);
    wait_idle(20);
    repeat (20) @(negedge clk);
    check("disable_single_xfer", n_accepted - acc0, 1);
    bus_read(REG_STATUS, d);
    check("disable_running", {31'd0, d[0]}, 32'd0);

    // Table pointer wrap: entries 7 and 0 written, pointer lands on 1.
    bus_write(REG_TBL_PTR, 7);
    bus_write(REG_TBL_DATA, 32'h5A);
    bus_write(REG_TBL_DATA, 32'hA5);
    read_check("ptr_wrap", REG_TBL_PTR, 32'd1);
    bus_write(REG_TBL_PTR, 7);
    read_check("tbl7_rb", REG_TBL_DATA, 32'h5A);
    bus_write(REG_TBL_PTR, 0);
    read_check("tbl0_rb", REG_TBL_DATA, 32'hA5);

    // PERIOD=0: one-shot writes A5,02,04 two cycles apart.
    bus_write(REG_PERIOD, 0);
    bus_write(REG_LENGTH, 2);
    expect_steps(3, 1'b1);
    bus_write(REG_CONTROL, 32'h3);
    wait_drain(100);
    wait_idle(20);
    read_check("p0_status", REG_STATUS, 32'h2);

    // Randomized one-shot runs; odd rounds add random wait states.
    for (int r = 0; r < 8; r++) begin
      bus_write(REG_TBL_PTR, 0);
      for (int i = 0; i < 8; i++) bus_write(REG_TBL_DATA, $urandom_range(0, 255));
      pick = $urandom_range(0, 7);
      bus_write(REG_TBL_PTR, pick);
      read_check("rand_tbl_rb", REG_TBL_DATA, {24'd0, sh_tbl[pick]});
      bus_write(REG_LENGTH, $urandom_range(0, 7));
      bus_write(REG_PERIOD, $urandom_range(0, 6));
      stall_rand = r[0];
      expect_steps(sh_length + 1, !stall_rand);
      bus_write(REG_CONTROL, 32'h3);
      wait_drain(2000);
      stall_rand = 1'b0;
      wait_idle(20);
      read_check("rand_status", REG_STATUS, 32'h2);
    end

    // Reset asserted while in DWELL.
    bus_write(REG_LENGTH, 2);
    bus_write(REG_PERIOD, 5);
    expect_steps(1, 1'b0);
    bus_write(REG_CONTROL, 32'h1);
    wait_drain(50);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_dwell");
    clear_shadow();
    read_check("rst_dwell_status", REG_STATUS, 32'h0);
    read_check("rst_dwell_control", REG_CONTROL, 32'h0);
    read_check("rst_dwell_period", REG_PERIOD, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-transfer in WRITE: chip select drops at once.
    acc0          = n_accepted;
    bus_write(REG_TBL_DATA, 32'h11);
    m_waitrequest = 1'b1;
    bus_write(REG_CONTROL, 32'h1);
    wait_cs(20);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_write");
    clear_shadow();
    read_check("rst_write_status", REG_STATUS, 32'h0);
    read_check("rst_write_tbl", REG_TBL_DATA, 32'h0);
    @(negedge clk);
    reset         = 1'b0;
    m_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_write_no_xfer", n_accepted - acc0, 0);
    read_check("rst_write_control", REG_CONTROL, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
